// File: rtl/iob_fifo_sync_asym_ctrl_pkg.sv
// rtl/iob_fifo_sync_asym_ctrl_pkg.sv - width-derivation helpers shared by the asymmetric FIFO controllers
package iob_fifo_sync_asym_ctrl_pkg;

    function automatic int iob_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int iob_min(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // The narrow side addresses every MINDATA_W unit; the wide side addresses groups of them.
    function automatic int side_addr_w(input int side_w, input int other_w,
                                       input int addr_w, input int minaddr_w);
        return (side_w <= other_w) ? addr_w : minaddr_w;
    endfunction

endpackage

// File: rtl/iob_fifo_asym_level.sv
// rtl/iob_fifo_asym_level.sv - fill level and full/empty flags from push/pop accept strobes
module iob_fifo_asym_level #(
    parameter int ADDR_W = 10,
    parameter int WRATIO = 4,
    parameter int RRATIO = 1
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              w_accept_i,
    input  logic              r_accept_i,
    output logic [ADDR_W:0]   level_o,
    output logic              w_full_o,
    output logic              r_empty_o
);

    localparam int LW = ADDR_W + 2;
    localparam logic [LW-1:0] W_INC    = LW'(WRATIO);
    localparam logic [LW-1:0] R_DEC    = LW'(RRATIO);
    localparam logic [LW-1:0] FULL_THR = LW'((2 ** ADDR_W) - WRATIO);

    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;

    // One extra bit of headroom keeps the simultaneous push/pop sum from wrapping.
    always_comb begin
        level_d = level_q;
        case ({w_accept_i, r_accept_i})
            2'b10:   level_d = level_q + W_INC;
            2'b01:   level_d = level_q - R_DEC;
            2'b11:   level_d = level_q + W_INC - R_DEC;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            level_q   <= '0;
            w_full_o  <= 1'b0;
            r_empty_o <= 1'b1;
        end else begin
            level_q   <= level_d;
            w_full_o  <= (level_d > FULL_THR);
            r_empty_o <= (level_d < R_DEC);
        end
    end

    assign level_o = level_q[ADDR_W:0];

endmodule

// File: rtl/iob_fifo_sync_asym_ctrl.sv
// rtl/iob_fifo_sync_asym_ctrl.sv - single-clock asymmetric-width FIFO controller for an external t2p RAM
// Optional sticky overflow/underflow flags: IOB_FIFO_SYNC_ASYM_ERR_EN
module iob_fifo_sync_asym_ctrl
    import iob_fifo_sync_asym_ctrl_pkg::*;
#(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 10,
    localparam int MAXDATA_W = iob_max(W_DATA_W, R_DATA_W),
    localparam int MINDATA_W = iob_min(W_DATA_W, R_DATA_W),
    localparam int MINADDR_W = ADDR_W - $clog2(MAXDATA_W / MINDATA_W),
    localparam int W_ADDR_W  = side_addr_w(W_DATA_W, R_DATA_W, ADDR_W, MINADDR_W),
    localparam int R_ADDR_W  = side_addr_w(R_DATA_W, W_DATA_W, ADDR_W, MINADDR_W),
    localparam int WRATIO    = W_DATA_W / MINDATA_W,
    localparam int RRATIO    = R_DATA_W / MINDATA_W
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
`ifdef IOB_FIFO_SYNC_ASYM_ERR_EN
    input  logic                err_clr_i,
    output logic                w_overflow_o,
    output logic                r_underflow_o,
`endif
    input  logic                w_en_i,
    input  logic [W_DATA_W-1:0] w_data_i,
    output logic                w_full_o,
    input  logic                r_en_i,
    output logic [R_DATA_W-1:0] r_data_o,
    output logic                r_valid_o,
    output logic                r_empty_o,
    output logic [ADDR_W:0]     level_o,
    output logic                ext_mem_w_en_o,
    output logic [W_ADDR_W-1:0] ext_mem_w_addr_o,
    output logic [W_DATA_W-1:0] ext_mem_w_data_o,
    output logic                ext_mem_r_en_o,
    output logic [R_ADDR_W-1:0] ext_mem_r_addr_o,
    input  logic [R_DATA_W-1:0] ext_mem_r_data_i
);

    logic                w_accept;
    logic                r_accept;
    logic [W_ADDR_W-1:0] w_ptr;
    logic [R_ADDR_W-1:0] r_ptr;

    assign w_accept = w_en_i && !w_full_o;
    assign r_accept = r_en_i && !r_empty_o;

    // Lane order falls out of the RAM address mapping, so data passes straight through.
    assign ext_mem_w_en_o   = w_accept;
    assign ext_mem_w_addr_o = w_ptr;
    assign ext_mem_w_data_o = w_data_i;
    assign ext_mem_r_en_o   = r_accept;
    assign ext_mem_r_addr_o = r_ptr;
    assign r_data_o         = ext_mem_r_data_i;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            r_valid_o <= 1'b0;
        end else begin
            if (w_accept) begin
                w_ptr <= w_ptr + W_ADDR_W'(1);
            end
            if (r_accept) begin
                r_ptr <= r_ptr + R_ADDR_W'(1);
            end
            r_valid_o <= r_accept;
        end
    end

    iob_fifo_asym_level #(
        .ADDR_W (ADDR_W),
        .WRATIO (WRATIO),
        .RRATIO (RRATIO)
    ) u_level (
        .clk_i      (clk_i),
        .arst_n_i   (arst_n_i),
        .w_accept_i (w_accept),
        .r_accept_i (r_accept),
        .level_o    (level_o),
        .w_full_o   (w_full_o),
        .r_empty_o  (r_empty_o)
    );

`ifdef IOB_FIFO_SYNC_ASYM_ERR_EN
    // Setting takes priority so an error in the clearing cycle is not lost.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            w_overflow_o  <= 1'b0;
            r_underflow_o <= 1'b0;
        end else begin
            if (w_en_i && w_full_o) begin
                w_overflow_o <= 1'b1;
            end else if (err_clr_i) begin
                w_overflow_o <= 1'b0;
            end
            if (r_en_i && r_empty_o) begin
                r_underflow_o <= 1'b1;
            end else if (err_clr_i) begin
                r_underflow_o <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_iob_fifo_sync_asym_ctrl.sv
// tb/tb_iob_fifo_sync_asym_ctrl.sv - scoreboard bench for the asymmetric FIFO controller with a behavioural RAM
module tb_iob_fifo_sync_asym_ctrl;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        w_en = 1'b0;
    logic [31:0] w_data = '0;
    logic        r_en = 1'b0;
    logic        w_full_o, r_valid_o, r_empty_o;
    logic [7:0]  r_data_o;
    logic [10:0] level_o;
    logic        ext_mem_w_en_o, ext_mem_r_en_o;
    logic [7:0]  ext_mem_w_addr_o;
    logic [31:0] ext_mem_w_data_o;
    logic [9:0]  ext_mem_r_addr_o;
    logic [7:0]  ram_rdata;
`ifdef IOB_FIFO_SYNC_ASYM_ERR_EN
    logic        err_clr = 1'b0;
    logic        w_overflow_o, r_underflow_o;
`endif

    int checks = 0;
    int failures = 0;
    int m_level = 0;
    logic [7:0] m_wptr = '0;
    logic [9:0] m_rptr = '0;
    logic [7:0] exp_q[$];
    logic [7:0] ram [0:1023];

    always #5 clk = ~clk;

    iob_fifo_sync_asym_ctrl dut (
        .clk_i            (clk),
        .arst_n_i         (arst_n),
`ifdef IOB_FIFO_SYNC_ASYM_ERR_EN
        .err_clr_i        (err_clr),
        .w_overflow_o     (w_overflow_o),
        .r_underflow_o    (r_underflow_o),
`endif
        .w_en_i           (w_en),
        .w_data_i         (w_data),
        .w_full_o         (w_full_o),
        .r_en_i           (r_en),
        .r_data_o         (r_data_o),
        .r_valid_o        (r_valid_o),
        .r_empty_o        (r_empty_o),
        .level_o          (level_o),
        .ext_mem_w_en_o   (ext_mem_w_en_o),
        .ext_mem_w_addr_o (ext_mem_w_addr_o),
        .ext_mem_w_data_o (ext_mem_w_data_o),
        .ext_mem_r_en_o   (ext_mem_r_en_o),
        .ext_mem_r_addr_o (ext_mem_r_addr_o),
        .ext_mem_r_data_i (ram_rdata)
    );

    // Byte-addressed RAM: lane k of wide word a sits at narrow address {a, k}.
    always @(posedge clk) begin
        if (ext_mem_w_en_o) begin
            for (int k = 0; k < 4; k++) begin
                ram[{ext_mem_w_addr_o, 2'(k)}] <= ext_mem_w_data_o[k*8 +: 8];
            end
        end
        if (ext_mem_r_en_o) begin
            ram_rdata <= ram[ext_mem_r_addr_o];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("level", 32'(level_o), m_level);
        chk("w_full", 32'(w_full_o), 32'(m_level > 1020));
        chk("r_empty", 32'(r_empty_o), 32'(m_level < 1));
    endtask

    // Called at posedge+1; drives one cycle of requests and returns at the next posedge+1.
    task automatic step(input logic we, input logic [31:0] wd, input logic re);
        logic wa, ra;
        wa = we && (m_level <= 1020);
        ra = re && (m_level >= 1);
        w_en = we; w_data = wd; r_en = re;
        #1;
        chk("w_mem_en", 32'(ext_mem_w_en_o), 32'(wa));
        chk("r_mem_en", 32'(ext_mem_r_en_o), 32'(ra));
        if (wa) begin
            chk("w_addr", 32'(ext_mem_w_addr_o), 32'(m_wptr));
            chk("w_mem_data", ext_mem_w_data_o, wd);
            for (int k = 0; k < 4; k++) exp_q.push_back(wd[k*8 +: 8]);
            m_wptr = m_wptr + 8'd1;
            m_level += 4;
        end
        if (ra) begin
            chk("r_addr", 32'(ext_mem_r_addr_o), 32'(m_rptr));
            m_rptr = m_rptr + 10'd1;
            m_level -= 1;
        end
        @(posedge clk);
        #1;
        w_en = 1'b0; r_en = 1'b0;
        chk("r_valid", 32'(r_valid_o), 32'(ra));
        if (ra) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("r_data", 32'(r_data_o), 32'(exp_q.pop_front()));
            end
        end
        check_state();
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        #2;
        m_level = 0; m_wptr = '0; m_rptr = '0;
        exp_q.delete();
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_empty", 32'(r_empty_o), 32'd1);
        chk("rst_full", 32'(w_full_o), 32'd0);
        chk("rst_valid", 32'(r_valid_o), 32'd0);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset state and rejected pop
        #12;
        do_reset();
        step(1'b0, 32'h0, 1'b1);

        // 2: one wide word drained as four little-endian bytes
        step(1'b1, 32'h0D0C0B0A, 1'b0);
        chk("level_after_push", 32'(level_o), 32'd4);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
        chk("empty_after_drain", 32'(r_empty_o), 32'd1);

        // 3: fill to capacity, then a rejected push
        do_reset();
        for (int i = 0; i < 256; i++) step(1'b1, 32'(i + 10), 1'b0);
        chk("full_level", 32'(level_o), 32'd1024);
        chk("full_flag", 32'(w_full_o), 32'd1);
        step(1'b1, 32'hDEADBEEF, 1'b0);
        chk("w_ptr_held", 32'(ext_mem_w_addr_o), 32'd0);
`ifdef IOB_FIFO_SYNC_ASYM_ERR_EN
        chk("overflow_set", 32'(w_overflow_o), 32'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("overflow_clr", 32'(w_overflow_o), 32'd0);
`endif

        // 4: drain to level 4, then simultaneous push and pop
        for (int i = 0; i < 1020; i++) step(1'b0, 32'h0, 1'b1);
        chk("level4", 32'(level_o), 32'd4);
        step(1'b1, 32'h44332211, 1'b1);
        chk("level7", 32'(level_o), 32'd7);

        // 5: balanced stream across two write-pointer wraps
        for (int i = 0; i < 600; i++) begin
            step(1'b1, 32'(i + 10), 1'b1);
            for (int j = 0; j < 3; j++) step(1'b0, 32'h0, 1'b1);
        end
        while (m_level > 0) step(1'b0, 32'h0, 1'b1);
        chk("stream_drained", 32'(exp_q.size()), 32'd0);
`ifdef IOB_FIFO_SYNC_ASYM_ERR_EN
        chk("no_underflow", 32'(r_underflow_o), 32'd0);
`endif

        // 6: asynchronous reset mid-stream at level 37
        for (int i = 0; i < 10; i++) step(1'b1, 32'(i + 100), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
        chk("level37", 32'(level_o), 32'd37);
        do_reset();
        step(1'b1, 32'h55667788, 1'b0);
        step(1'b0, 32'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iob_fifo_sync_asym_ctrl.md
Name: iob_fifo_sync_asym_ctrl

Overview:
Single-clock FIFO controller with asymmetric write and read widths. It drives an external iob_ram_t2p_asym instance through ext_mem_* ports, with both RAM clocks tied to clk_i.
- Owns the write and read pointers, the fill level, full/empty flags and read-data valid.
- Upstream producers push W_DATA_W words; downstream consumers pop R_DATA_W words in little-endian lane order.

Parameters:
W_DATA_W, 32, write word width; must be MINDATA_W times a power of 2
R_DATA_W, 8, read word width; same constraint
ADDR_W, 10, address width of the narrower side; capacity is 2**ADDR_W MINDATA_W units
Derived localparams:
- MAXDATA_W = IOB_MAX(W,R); MINDATA_W = IOB_MIN(W,R)
- MINADDR_W = ADDR_W - log2(MAXDATA_W/MINDATA_W)
- W_ADDR_W and R_ADDR_W: ADDR_W on the narrow side, MINADDR_W on the wide side
- WRATIO = W_DATA_W/MINDATA_W; RRATIO = R_DATA_W/MINDATA_W

Ports:
clk_i  in  1  clock, rising edge
arst_n_i  in  1  reset, asynchronous, active-low
w_en_i  in  1  push request
w_data_i  in  W_DATA_W  push data
w_full_o  out  1  push would overflow
r_en_i  in  1  pop request
r_data_o  out  R_DATA_W  pop data, valid when r_valid_o
r_valid_o  out  1  pop data valid
r_empty_o  out  1  fewer than RRATIO units stored
level_o  out  ADDR_W+1  fill level in MINDATA_W units
ext_mem_w_en_o  out  1  RAM write enable
ext_mem_w_addr_o  out  W_ADDR_W  RAM write address
ext_mem_w_data_o  out  W_DATA_W  RAM write data
ext_mem_r_en_o  out  1  RAM read enable
ext_mem_r_addr_o  out  R_ADDR_W  RAM read address
ext_mem_r_data_i  in  R_DATA_W  RAM read data, one cycle after ext_mem_r_en_o

Behaviour:
- Reset (asynchronous, active-low) sets: w_ptr=0, r_ptr=0, level_o=0, w_full_o=0, r_empty_o=1, r_valid_o=0. RAM contents are not cleared.
- Push accepted when w_en_i && !w_full_o:
  - ext_mem_w_en_o=1, ext_mem_w_addr_o=w_ptr, ext_mem_w_data_o=w_data_i, all combinational in the same cycle.
  - w_ptr increments and wraps modulo 2**W_ADDR_W.
- Pop accepted when r_en_i && !r_empty_o:
  - ext_mem_r_en_o=1, ext_mem_r_addr_o=r_ptr, same cycle.
  - r_ptr increments and wraps modulo 2**R_ADDR_W.
  - r_valid_o=1 on the next cycle; r_data_o = ext_mem_r_data_i passthrough.
- Rejected requests: push while full and pop while empty have no side effects. No RAM enable, no pointer or level change.
- Level update, registered:
  - push only: level += WRATIO
  - pop only: level -= RRATIO
  - both accepted in the same cycle: level += WRATIO - RRATIO, arithmetic done in ADDR_W+2 bits
- Flags, registered and derived from the next level:
  - w_full_o = next_level > 2**ADDR_W - WRATIO
  - r_empty_o = next_level < RRATIO
- Lane order: lane k of a wide write word (bits k*MINDATA_W +: MINDATA_W) is read out before lane k+1. Ordering is fixed by RAM address mapping; no reordering logic.
- Same-cycle write and read to the same RAM address cannot occur. Pop requires the data to be already counted in level.
- Pointers are not a state machine. Full/empty are decided only by level_o, never by pointer comparison.

Optional Feature:
IOB_FIFO_SYNC_ASYM_ERR_EN
- Defined: adds ports err_clr_i (in,1), w_overflow_o (out,1) and r_underflow_o (out,1).
  - w_overflow_o sets on w_en_i&&w_full_o; r_underflow_o sets on r_en_i&&r_empty_o.
  - Both are sticky; cleared by reset or by err_clr_i=1. Set wins over clear in the same cycle.
- Undefined: these ports and registers do not exist; rejected requests are silently dropped.

Decomposition:
- Width-derivation localparams (MAXDATA_W, MINDATA_W, MINADDR_W, W_ADDR_W, R_ADDR_W, WRATIO, RRATIO) live in the shared header iob_fifo_asym.vh. IOB_MAX/IOB_MIN come from iob_lib.vh; the header is shared with the RAM bench and a future async variant.
- One natural sub-module: iob_fifo_asym_level. It takes accept strobes and produces level_o, w_full_o and r_empty_o, so it can be reused by the async variant.

Test Plan:
Default parameters: W=32, R=8, ADDR_W=10, capacity 1024 bytes, W_ADDR_W=8, R_ADDR_W=10.
1. Reset release -> level_o=0, r_empty_o=1, w_full_o=0, r_valid_o=0; pop request gives no ext_mem_r_en_o.
2. Push 0x0D0C0B0A, then 4 pops -> r_data_o 0x0A,0x0B,0x0C,0x0D, each with r_valid_o one cycle after the pop. r_empty_o=1 after the 4th pop; level_o 4->0.
3. 256 pushes of i+10 -> w_full_o=1, level_o=1024. 257th push: no ext_mem_w_en_o, w_ptr stays 0. With ERR_EN, w_overflow_o=1 until err_clr_i.
4. Level 4, push and pop in the same cycle -> level_o=7, both RAM enables high, flags unchanged.
5. Stream 600 pushes with pops interleaved at 4:1 byte rate, crossing pointer wrap twice -> byte stream equals the little-endian lanes of i+10 with no loss; r_underflow_o stays 0.
6. arst_n_i low mid-stream at level 37 -> level_o=0, r_empty_o=1 and r_valid_o=0 immediately, asynchronous, before the next edge. Next push lands at ext_mem_w_addr_o=0.
